// File: rtl/dav_tx.sv
`default_nettype none
// ============================================================================
// Module   : dav_tx
// Purpose  : Inter-FPGA DAV line transmitter. Fixed-width pulses, guaranteed
//            low gaps, saturating request queue, KILL re-arm.
// Revision : 1.0  initial release
// ============================================================================
module dav_tx #(
    parameter int PW      = 2,
    parameter int GAP     = 2,
    parameter int ARM_LOW = 8,
    parameter int CW      = 4
) (
    input  logic          C,
    input  logic          RST,
    input  logic          REQ,
    input  logic          KILL,
    output logic          Q,
    output logic          BUSY,
    output logic [CW-1:0] PEND,
    output logic          OVF
);

    localparam int c_TMAX_PG = (PW > GAP) ? PW : GAP;
    localparam int c_TMAX    = (c_TMAX_PG > ARM_LOW) ? c_TMAX_PG : ARM_LOW;
    localparam int c_TW      = $clog2(c_TMAX + 1);

    localparam logic [c_TW-1:0] c_PW_END   = c_TW'(PW - 1);
    localparam logic [c_TW-1:0] c_GAP_END  = c_TW'(GAP - 1);
    localparam logic [c_TW-1:0] c_ARM_END  = c_TW'(ARM_LOW - 1);
    localparam logic [c_TW-1:0] c_TMR_ONE  = c_TW'(1);
    localparam logic [CW-1:0]   c_PEND_MAX = {CW{1'b1}};
    localparam logic [CW-1:0]   c_PEND_ONE = CW'(1);

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [c_TW-1:0]   r_tmr;
    logic [c_TW-1:0]   w_tmr_nx;
    logic [CW-1:0]     r_pend;
    logic [CW-1:0]     w_pend_nx;
    logic              r_ovf;
    logic              w_ovf_nx;
    logic              w_start;
    logic              w_work;
    (* IOB = "TRUE" *) logic r_q;
    logic              r_busy;

    assign w_work = REQ || (r_pend != '0);

    always_comb begin
        w_state_nx = r_state;
        w_tmr_nx   = r_tmr;
        w_pend_nx  = r_pend;
        w_ovf_nx   = r_ovf;
        w_start    = 1'b0;

        case (r_state)
            ST_ARM: begin
                if (r_tmr == c_ARM_END) begin
                    w_state_nx = ST_IDLE;
                    w_tmr_nx   = '0;
                end else begin
                    w_tmr_nx = r_tmr + c_TMR_ONE;
                end
            end
            ST_IDLE: begin
                if (w_work) begin
                    w_start    = 1'b1;
                    w_state_nx = ST_HIGH;
                    w_tmr_nx   = '0;
                end
            end
            ST_HIGH: begin
                if (r_tmr == c_PW_END) begin
                    w_state_nx = ST_LOW;
                    w_tmr_nx   = '0;
                end else begin
                    w_tmr_nx = r_tmr + c_TMR_ONE;
                end
            end
            default: begin
                // Queued work leaves LOW straight into HIGH, no IDLE bubble.
                if (r_tmr == c_GAP_END) begin
                    w_tmr_nx = '0;
                    if (w_work) begin
                        w_start    = 1'b1;
                        w_state_nx = ST_HIGH;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end else begin
                    w_tmr_nx = r_tmr + c_TMR_ONE;
                end
            end
        endcase

        if (w_start) begin
            if (!REQ) begin
                w_pend_nx = r_pend - c_PEND_ONE;
            end
        end else if (REQ) begin
            if (r_pend == c_PEND_MAX) begin
                w_ovf_nx = 1'b1;
            end else begin
                w_pend_nx = r_pend + c_PEND_ONE;
            end
        end

        // KILL overrides everything except RST; OVF history is kept.
        if (KILL) begin
            w_state_nx = ST_ARM;
            w_tmr_nx   = '0;
            w_pend_nx  = '0;
            w_ovf_nx   = r_ovf;
        end
    end

    always_ff @(posedge C) begin
        if (RST) begin
            r_state <= ST_ARM;
            r_tmr   <= '0;
            r_pend  <= '0;
            r_ovf   <= 1'b0;
            r_q     <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_tmr   <= w_tmr_nx;
            r_pend  <= w_pend_nx;
            r_ovf   <= w_ovf_nx;
            r_q     <= (w_state_nx == ST_HIGH);
            r_busy  <= (w_state_nx != ST_IDLE) || (w_pend_nx != '0);
        end
    end

    assign Q    = r_q;
    assign BUSY = r_busy;
    assign PEND = r_pend;
    assign OVF  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_dav_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_dav_tx
// Purpose  : Directed self-checking bench for dav_tx (PW=2, GAP=2, ARM_LOW=8,
//            CW=2 so the queue saturates after three entries).
// Revision : 1.0  initial release
// ============================================================================
module tb_dav_tx;

    logic       C;
    logic       RST;
    logic       REQ;
    logic       KILL;
    logic       Q;
    logic       BUSY;
    logic [1:0] PEND;
    logic       OVF;

    int errors = 0;
    int checks = 0;

    dav_tx #(
        .PW      (2),
        .GAP     (2),
        .ARM_LOW (8),
        .CW      (2)
    ) u_dut (
        .C    (C),
        .RST  (RST),
        .REQ  (REQ),
        .KILL (KILL),
        .Q    (Q),
        .BUSY (BUSY),
        .PEND (PEND),
        .OVF  (OVF)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Expected values indexed by edge offset j from the first REQ edge.
    int q3[13]    = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0};
    int busy3[13] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int pend3[13] = '{0, 1, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    int pend5[20] = '{0, 1, 2, 3, 3, 3, 3, 3, 2, 2, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0};

    initial begin
        int rises;
        int prev_q;

        RST  = 1'b1;
        REQ  = 1'b0;
        KILL = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_q", Q, 0);
        chk("rst_busy", BUSY, 1);
        chk("rst_pend", PEND, 0);
        chk("rst_ovf", OVF, 0);
        RST = 1'b0;

        // Idle arm-out: BUSY high for exactly 8 cycles, Q never rises.
        for (int i = 1; i <= 19; i++) begin
            tick();
            chk("t1_q", Q, 0);
            chk("t1_busy", BUSY, (i < 8) ? 1 : 0);
            chk("t1_pend", PEND, 0);
        end

        // Single request from IDLE: one-clock latency, 2 high, 2 low.
        REQ = 1'b1;
        tick();
        REQ = 1'b0;
        chk("t2_q_rise", Q, 1);
        chk("t2_pend", PEND, 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("t2_q", Q, (k == 1) ? 1 : 0);
            chk("t2_busy", BUSY, (k < 4) ? 1 : 0);
        end

        // Three back-to-back requests: pulses every 4 cycles, no IDLE bubble.
        for (int j = 0; j < 13; j++) begin
            REQ = (j < 3);
            tick();
            chk("t3_q", Q, q3[j]);
            chk("t3_busy", BUSY, busy3[j]);
            chk("t3_pend", PEND, pend3[j]);
        end
        REQ = 1'b0;

        // Six requests into a 3-deep queue: one dropped, five pulses, OVF sticks.
        rises  = 0;
        prev_q = 0;
        for (int j = 0; j < 26; j++) begin
            REQ = (j < 6);
            tick();
            if (Q == 1'b1 && prev_q == 0) rises++;
            prev_q = Q;
            chk("t5_q", Q, (j < 18 && (j % 4) < 2) ? 1 : 0);
            chk("t5_ovf", OVF, (j >= 5) ? 1 : 0);
            if (j < 20) chk("t5_pend", PEND, pend5[j]);
            chk("t5_busy", BUSY, (j < 20) ? 1 : 0);
        end
        REQ = 1'b0;
        chk("t5_pulses", rises, 5);

        // KILL ignores REQ, keeps OVF, then re-arms.
        KILL = 1'b1;
        REQ  = 1'b1;
        for (int j = 0; j < 2; j++) begin
            tick();
            chk("kill_q", Q, 0);
            chk("kill_pend", PEND, 0);
            chk("kill_busy", BUSY, 1);
            chk("kill_ovf", OVF, 1);
        end
        KILL = 1'b0;

        // Requests queued during ARM; first rise one cycle after ARM ends.
        for (int m = 1; m <= 9; m++) begin
            REQ = (m <= 3);
            tick();
            chk("t4_pend", PEND, (m <= 3) ? m : ((m == 9) ? 2 : 3));
            chk("t4_q", Q, (m == 9) ? 1 : 0);
            chk("t4_busy", BUSY, 1);
        end
        REQ = 1'b0;

        // KILL on the first high cycle with two still queued.
        KILL = 1'b1;
        tick();
        KILL = 1'b0;
        chk("t6_q_drop", Q, 0);
        chk("t6_pend", PEND, 0);
        chk("t6_ovf", OVF, 1);
        for (int m = 1; m <= 20; m++) begin
            tick();
            chk("t6_q_low", Q, 0);
            chk("t6_busy", BUSY, (m < 8) ? 1 : 0);
            chk("t6_pend_idle", PEND, 0);
        end
        chk("t6_ovf_held", OVF, 1);

        // Only RST clears OVF.
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rst2_ovf", OVF, 0);
        chk("rst2_busy", BUSY, 1);
        chk("rst2_q", Q, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
